// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-write scoreboard with one set, one clear and two lookup ports
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_addr,
    input  logic [REG_AW-1:0]   rd_addr_a,
    input  logic [REG_AW-1:0]   rd_addr_b,
    output logic                rd_a,
    output logic                rd_b,
    output logic [NUM_REGS-1:0] pend_map
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_next;

    // Clear is applied before set so a same-cycle set of the same register wins.
    always_comb begin
        pend_next = pend_q;
        if (clr_en) begin
            pend_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pend_next[set_addr] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_next;
        end
    end

    assign rd_a     = (rd_addr_a != '0) && pend_q[rd_addr_a];
    assign rd_b     = (rd_addr_b != '0) && pend_q[rd_addr_b];
    assign pend_map = pend_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with register scoreboard and memory timeout
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ID_inst_en,
    input  logic [REG_AW-1:0]   ID_Rs,
    input  logic [REG_AW-1:0]   ID_Rt,
    input  logic [REG_AW-1:0]   ID_Rdst,
    input  logic                ID_RegW,
    input  logic                MEM_busy,
    input  logic                EX_branch_taken,
    input  logic                WB_inst_en,
    input  logic                WB_RegW,
    input  logic [REG_AW-1:0]   WB_Rdst,
    output logic                Stall,
    output logic                flush_IF_ID,
    output logic                flush_ID_EX,
    output logic                issue,
    output logic [NUM_REGS-1:0] pend_map,
    output logic                mem_timeout
);

    localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

    state_t     state, state_next;
    logic [2:0] flush_cnt, flush_cnt_next;
    logic       br_pend, br_pend_next;
    logic [7:0] busy_cnt, busy_cnt_next;
    logic       rd_a, rd_b, hazard;
    logic       set_en, clr_en;

    hazard_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_en),
        .set_addr  (ID_Rdst),
        .clr_en    (clr_en),
        .clr_addr  (WB_Rdst),
        .rd_addr_a (ID_Rs),
        .rd_addr_b (ID_Rt),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .pend_map  (pend_map)
    );

    assign hazard = ID_inst_en && (rd_a || rd_b);

    // Combinational outputs are gated by rst so nothing follows the inputs during reset.
    assign Stall       = !rst && (hazard || MEM_busy || (state == ST_MEMWAIT));
    assign flush_IF_ID = !rst && (state == ST_FLUSH);
    assign flush_ID_EX = !rst && (state == ST_FLUSH);
    assign issue       = !rst && ID_inst_en && !Stall && (state == ST_RUN);

    assign set_en = issue && ID_RegW && (ID_Rdst != '0);
    assign clr_en = WB_inst_en && WB_RegW && (WB_Rdst != '0);

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        br_pend_next   = br_pend;
        case (state)
            ST_RUN: begin
                if (MEM_busy) begin
                    state_next   = ST_MEMWAIT;
                    br_pend_next = EX_branch_taken;
                end else if (EX_branch_taken) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FC_LOAD;
                end
            end
            ST_MEMWAIT: begin
                if (!MEM_busy) begin
                    if (br_pend || EX_branch_taken) begin
                        state_next     = ST_FLUSH;
                        flush_cnt_next = FC_LOAD;
                        br_pend_next   = 1'b0;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else if (EX_branch_taken) begin
                    br_pend_next = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (EX_branch_taken) begin
                    flush_cnt_next = FC_LOAD;
                end else if (!MEM_busy) begin
                    if (flush_cnt <= 3'd1) begin
                        state_next     = ST_RUN;
                        flush_cnt_next = 3'd0;
                    end else begin
                        flush_cnt_next = flush_cnt - 3'd1;
                    end
                end
            end
            default: begin
                state_next     = ST_RUN;
                flush_cnt_next = 3'd0;
                br_pend_next   = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy_cnt_next = 8'd0;
        if (MEM_busy) begin
            busy_cnt_next = (busy_cnt == 8'hFF) ? busy_cnt : busy_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            flush_cnt   <= 3'd0;
            br_pend     <= 1'b0;
            busy_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            br_pend   <= br_pend_next;
            busy_cnt  <= busy_cnt_next;
            if (MEM_busy && (busy_cnt_next >= TMO_LIM)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int FC = 2;
    localparam int MT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_inst_en, ID_RegW, MEM_busy, EX_branch_taken, WB_inst_en, WB_RegW;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rdst, WB_Rdst;
    logic        Stall, flush_IF_ID, flush_ID_EX, issue, mem_timeout;
    logic [31:0] pend_map;

    int errors = 0;
    int checks = 0;

    // model state
    bit [31:0] m_pend;
    int        m_flush_left;
    bit        m_memwait;
    bit        m_br_pend;
    int        m_busy_run;
    bit        m_tmo;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_inst_en      (ID_inst_en),
        .ID_Rs           (ID_Rs),
        .ID_Rt           (ID_Rt),
        .ID_Rdst         (ID_Rdst),
        .ID_RegW         (ID_RegW),
        .MEM_busy        (MEM_busy),
        .EX_branch_taken (EX_branch_taken),
        .WB_inst_en      (WB_inst_en),
        .WB_RegW         (WB_RegW),
        .WB_Rdst         (WB_Rdst),
        .Stall           (Stall),
        .flush_IF_ID     (flush_IF_ID),
        .flush_ID_EX     (flush_ID_EX),
        .issue           (issue),
        .pend_map        (pend_map),
        .mem_timeout     (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_flush_left = 0;
        m_memwait = 0;
        m_br_pend = 0;
        m_busy_run = 0;
        m_tmo = 0;
    endtask

    function automatic bit exp_stall();
        bit hz;
        hz = ID_inst_en && ((ID_Rs != 0 && m_pend[ID_Rs]) || (ID_Rt != 0 && m_pend[ID_Rt]));
        return hz || MEM_busy || m_memwait;
    endfunction

    function automatic bit exp_issue();
        return ID_inst_en && !exp_stall() && !m_memwait && (m_flush_left == 0);
    endfunction

    task automatic compare();
        check("stall", 32'(Stall), 32'(exp_stall()));
        check("flush_if_id", 32'(flush_IF_ID), 32'(m_flush_left > 0));
        check("flush_id_ex", 32'(flush_ID_EX), 32'(m_flush_left > 0));
        check("issue", 32'(issue), 32'(exp_issue()));
        check("pend_map", pend_map, m_pend);
        check("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
    endtask

    task automatic model_step();
        bit iss;
        iss = exp_issue();
        if (WB_inst_en && WB_RegW && WB_Rdst != 0) m_pend[WB_Rdst] = 1'b0;
        if (iss && ID_RegW && ID_Rdst != 0) m_pend[ID_Rdst] = 1'b1;
        m_busy_run = MEM_busy ? ((m_busy_run < 255) ? m_busy_run + 1 : 255) : 0;
        if (m_busy_run >= MT) m_tmo = 1;
        if (m_flush_left > 0) begin
            if (EX_branch_taken) m_flush_left = FC;
            else if (!MEM_busy) m_flush_left = m_flush_left - 1;
        end else if (m_memwait) begin
            if (EX_branch_taken) m_br_pend = 1;
            if (!MEM_busy) begin
                m_memwait = 0;
                if (m_br_pend) begin
                    m_flush_left = FC;
                    m_br_pend = 0;
                end
            end
        end else if (MEM_busy) begin
            m_memwait = 1;
            m_br_pend = EX_branch_taken;
        end else if (EX_branch_taken) begin
            m_flush_left = FC;
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic cycle();
        #1 compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        ID_inst_en = 0; ID_Rs = 0; ID_Rt = 0; ID_Rdst = 0; ID_RegW = 0;
        MEM_busy = 0; EX_branch_taken = 0;
        WB_inst_en = 0; WB_RegW = 0; WB_Rdst = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_issue", 32'(issue), 32'd0);
        check("rst_flush", 32'({flush_IF_ID, flush_ID_EX}), 32'd0);
        check("rst_pend", pend_map, 32'd0);
        check("rst_tmo", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        idle();
    endtask

    initial begin
        bit   prev_busy, prev_br;
        logic [7:0] fl_vec;
        int   fl_cnt, iss_in_flush;

        idle();
        // Active inputs during reset must not reach the outputs.
        ID_inst_en = 1; MEM_busy = 1; EX_branch_taken = 1;
        do_reset();

        // RAW hazard on r5, released by writeback
        ID_inst_en = 1; ID_Rdst = 5; ID_RegW = 1;
        cycle();
        ID_RegW = 0; ID_Rdst = 0; ID_Rs = 5;
        #1;
        check("raw_stall", 32'(Stall), 32'd1);
        check("raw_issue", 32'(issue), 32'd0);
        WB_inst_en = 1; WB_RegW = 1; WB_Rdst = 5;
        cycle();
        WB_inst_en = 0; WB_RegW = 0; WB_Rdst = 0;
        #1;
        check("raw_release_stall", 32'(Stall), 32'd0);
        check("raw_release_issue", 32'(issue), 32'd1);
        cycle();

        // r0 is never pending
        ID_Rs = 0; ID_Rt = 0; ID_Rdst = 0; ID_RegW = 1;
        cycle();
        ID_RegW = 0;
        #1;
        check("r0_pend", pend_map, 32'd0);
        check("r0_stall", 32'(Stall), 32'd0);
        cycle();

        // same-cycle set and clear of r7
        ID_Rdst = 7; ID_RegW = 1;
        WB_inst_en = 1; WB_RegW = 1; WB_Rdst = 7;
        cycle();
        idle();
        #1 check("set_wins", 32'(pend_map[7]), 32'd1);
        WB_inst_en = 1; WB_RegW = 1; WB_Rdst = 7;
        cycle();
        idle();

        // branch in RUN: flush for exactly FC cycles, no issue meanwhile
        EX_branch_taken = 1;
        cycle();
        EX_branch_taken = 0; ID_inst_en = 1;
        fl_cnt = 0; iss_in_flush = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (flush_IF_ID) begin
                fl_cnt++;
                if (issue) iss_in_flush++;
            end
            cycle();
        end
        check("flush_len", 32'(fl_cnt), 32'd2);
        check("flush_no_issue", 32'(iss_in_flush), 32'd0);
        idle();

        // branch during MEM_busy is deferred until busy drops
        fl_vec = '0;
        for (int i = 0; i < 8; i++) begin
            MEM_busy = (i < 3);
            EX_branch_taken = (i == 0);
            #1 fl_vec[i] = flush_ID_EX;
            cycle();
        end
        check("deferred_flush", 32'(fl_vec), 32'h30);
        idle();

        // randomized phase
        prev_busy = 0; prev_br = 0;
        for (int n = 0; n < 500; n++) begin
            ID_inst_en = ($urandom % 4) != 0;
            ID_Rs = 5'($urandom % 8);
            ID_Rt = 5'($urandom % 8);
            ID_Rdst = 5'($urandom % 8);
            ID_RegW = $urandom % 2;
            MEM_busy = prev_busy ? (($urandom % 3) != 0) : (($urandom % 8) == 0);
            EX_branch_taken = !prev_br && (($urandom % 10) == 0);
            WB_inst_en = $urandom % 2;
            WB_RegW = $urandom % 2;
            WB_Rdst = 5'($urandom % 8);
            prev_busy = MEM_busy;
            prev_br = EX_branch_taken;
            cycle();
        end
        idle();
        cycle();

        // memory timeout: 14 busy cycles is not enough, 15 sets a sticky flag
        do_reset();
        MEM_busy = 1;
        repeat (14) cycle();
        MEM_busy = 0;
        #1 check("tmo_14", 32'(mem_timeout), 32'd0);
        cycle();
        MEM_busy = 1;
        repeat (15) cycle();
        #1 check("tmo_15", 32'(mem_timeout), 32'd1);
        MEM_busy = 0;
        repeat (3) cycle();
        check("tmo_sticky", 32'(mem_timeout), 32'd1);

        // reset in the middle of a flush
        EX_branch_taken = 1;
        cycle();
        EX_branch_taken = 0;
        #1 check("pre_rst_flush", 32'(flush_IF_ID), 32'd1);
        ID_inst_en = 1; MEM_busy = 1;
        rst = 1;
        #1;
        check("midflush_outputs",
              32'({Stall, flush_IF_ID, flush_ID_EX, issue, mem_timeout}), 32'd0);
        check("midflush_pend", pend_map, 32'd0);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
